// File: rtl/alu_op_issuer.sv
// alu_op_issuer
//   Sequential front end for a combinational N-bit ALU (ctrl 00 ADD, 01 SUB,
//   10 AND, 11 OR). It accepts one opcode/operand request at a time, drives
//   the ALU from registers, samples the result and carry-out, derives the
//   N/Z/C/V flags and returns them over a response handshake.
//
// Ports
//   i_clk, i_rst            clock, asynchronous active-high reset
//   i_req_valid/o_req_ready request handshake (ready only in IDLE)
//   i_req_op                000 ADD 001 SUB 010 AND 011 OR 100 CMP 101 NEG
//                           110 MOV 111 illegal
//   i_req_a, i_req_b        request operands
//   o_alu_a, o_alu_b        registered ALU operands
//   o_alu_ctrl              registered ALU control
//   i_alu_result            ALU result
//   i_alu_carry_out         ALU carry-out (1 = no borrow for subtraction)
//   o_rsp_valid/i_rsp_ready response handshake
//   o_rsp_result            response result
//   o_rsp_flags             {N, Z, C, V}
//   o_rsp_error             illegal opcode indication
module alu_op_issuer #(
  parameter int unsigned N = 64
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_req_valid,
  output logic         o_req_ready,
  input  logic [2:0]   i_req_op,
  input  logic [N-1:0] i_req_a,
  input  logic [N-1:0] i_req_b,
  output logic [N-1:0] o_alu_a,
  output logic [N-1:0] o_alu_b,
  output logic [1:0]   o_alu_ctrl,
  input  logic [N-1:0] i_alu_result,
  input  logic         i_alu_carry_out,
  output logic         o_rsp_valid,
  input  logic         i_rsp_ready,
  output logic [N-1:0] o_rsp_result,
  output logic [3:0]   o_rsp_flags,
  output logic         o_rsp_error
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000, OP_SUB = 3'b001, OP_AND = 3'b010, OP_OR  = 3'b011,
    OP_CMP = 3'b100, OP_NEG = 3'b101, OP_MOV = 3'b110, OP_ILL = 3'b111
  } op_t;

  state_t       r_state;
  state_t       w_next_state;
  op_t          r_op;
  logic [N-1:0] r_alu_a;
  logic [N-1:0] r_alu_b;
  logic [1:0]   r_alu_ctrl;
  logic [N-1:0] r_rsp_result;
  logic [3:0]   r_rsp_flags;
  logic         r_rsp_error;

  logic         w_accept;
  logic         w_illegal;
  logic [N-1:0] w_dec_a;
  logic [N-1:0] w_dec_b;
  logic [1:0]   w_dec_ctrl;
  logic         w_arith;
  logic [N-1:0] w_be;
  logic [N-1:0] w_res;
  logic [3:0]   w_flags;

  assign w_accept  = (r_state == S_IDLE) && i_req_valid;
  assign w_illegal = (i_req_op == OP_ILL);

  // State register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  // Next-state logic; an illegal opcode skips EXEC
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: if (i_req_valid) w_next_state = w_illegal ? S_RESP : S_EXEC;
      S_EXEC: w_next_state = S_RESP;
      S_RESP: if (i_rsp_ready) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Handshake outputs decoded from state only
  always_comb begin
    o_req_ready = (r_state == S_IDLE);
    o_rsp_valid = (r_state == S_RESP);
  end

  // Request decode into ALU operands/control
  always_comb begin
    w_dec_a    = i_req_a;
    w_dec_b    = i_req_b;
    w_dec_ctrl = 2'b00;
    case (i_req_op)
      OP_ADD: w_dec_ctrl = 2'b00;
      OP_SUB: w_dec_ctrl = 2'b01;
      OP_AND: w_dec_ctrl = 2'b10;
      OP_OR:  w_dec_ctrl = 2'b11;
      OP_CMP: w_dec_ctrl = 2'b01;
      OP_NEG: begin w_dec_a = '0; w_dec_ctrl = 2'b01; end
      OP_MOV: begin w_dec_a = '0; w_dec_ctrl = 2'b11; end
      default: w_dec_ctrl = 2'b00;
    endcase
  end

  // Flag derivation from the sampled ALU result; effective B is inverted
  // for the subtraction-class ops so V uses the true addend sign.
  always_comb begin
    w_arith = (r_op == OP_ADD) || (r_op == OP_SUB) ||
              (r_op == OP_CMP) || (r_op == OP_NEG);
    w_be    = (r_op == OP_ADD) ? r_alu_b : ~r_alu_b;
    w_flags[3] = i_alu_result[N-1];
    w_flags[2] = (i_alu_result == '0);
    w_flags[1] = w_arith && i_alu_carry_out;
    w_flags[0] = w_arith && (r_alu_a[N-1] == w_be[N-1]) &&
                 (i_alu_result[N-1] != r_alu_a[N-1]);
    w_res   = (r_op == OP_CMP) ? '0 : i_alu_result;
  end

  // Datapath registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_op         <= OP_ADD;
      r_alu_a      <= '0;
      r_alu_b      <= '0;
      r_alu_ctrl   <= 2'b00;
      r_rsp_result <= '0;
      r_rsp_flags  <= '0;
      r_rsp_error  <= 1'b0;
    end else if (w_accept) begin
      if (w_illegal) begin
        r_rsp_result <= '0;
        r_rsp_flags  <= '0;
        r_rsp_error  <= 1'b1;
      end else begin
        r_op       <= op_t'(i_req_op);
        r_alu_a    <= w_dec_a;
        r_alu_b    <= w_dec_b;
        r_alu_ctrl <= w_dec_ctrl;
      end
    end else if (r_state == S_EXEC) begin
      r_rsp_result <= w_res;
      r_rsp_flags  <= w_flags;
      r_rsp_error  <= 1'b0;
    end
  end

  assign o_alu_a      = r_alu_a;
  assign o_alu_b      = r_alu_b;
  assign o_alu_ctrl   = r_alu_ctrl;
  assign o_rsp_result = r_rsp_result;
  assign o_rsp_flags  = r_rsp_flags;
  assign o_rsp_error  = r_rsp_error;

endmodule

// File: tb/tb_alu_op_issuer.sv
module tb_alu_op_issuer;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic [2:0] req_op;
  logic [7:0] req_a, req_b;
  logic [7:0] alu_a, alu_b;
  logic [1:0] alu_ctrl;
  logic [7:0] alu_result;
  logic       alu_carry;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_result;
  logic [3:0] rsp_flags;
  logic       rsp_error;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  alu_op_issuer #(.N(8)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_op(req_op),
    .i_req_a(req_a), .i_req_b(req_b),
    .o_alu_a(alu_a), .o_alu_b(alu_b), .o_alu_ctrl(alu_ctrl),
    .i_alu_result(alu_result), .i_alu_carry_out(alu_carry),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
    .o_rsp_result(rsp_result), .o_rsp_flags(rsp_flags), .o_rsp_error(rsp_error)
  );

  // Combinational ALU the block is meant to drive
  logic [8:0] alu_sum;
  always_comb begin
    case (alu_ctrl)
      2'b00:   alu_sum = {1'b0, alu_a} + {1'b0, alu_b};
      2'b01:   alu_sum = {1'b0, alu_a} + {1'b0, ~alu_b} + 9'd1;
      2'b10:   alu_sum = {1'b0, alu_a & alu_b};
      default: alu_sum = {1'b0, alu_a | alu_b};
    endcase
  end
  assign alu_result = alu_sum[7:0];
  assign alu_carry  = alu_sum[8];

  // Drives one request, observes ALU drive one cycle after acceptance,
  // waits (bounded) for the response, then completes the handshake.
  task automatic issue(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                       output logic [7:0] res, output logic [3:0] fl, output logic err,
                       output int lat, output logic [1:0] ctrl, output logic [7:0] oa);
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    ctrl = alu_ctrl; oa = alu_a;
    lat = 1;
    while (!rsp_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    res = rsp_result; fl = rsp_flags; err = rsp_error;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b0; req_op = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_result !== 8'h00 ||
        rsp_flags !== 4'h0 || rsp_error !== 1'b0 || alu_a !== 8'h00 ||
        alu_b !== 8'h00 || alu_ctrl !== 2'b00) begin
      fails++;
      $display("FAIL reset_state: rdy=%b vld=%b res=%h fl=%b err=%b a=%h b=%h ctrl=%b (required 1 0 00 0000 0 00 00 00)",
               req_ready, rsp_valid, rsp_result, rsp_flags, rsp_error, alu_a, alu_b, alu_ctrl);
    end
  endtask

  typedef struct {
    string      name;
    logic [2:0] op;
    logic [7:0] a, b;
    logic [7:0] res;
    logic [3:0] fl;
    logic       err;
    int         lat;
    logic [1:0] ctrl;
    logic [7:0] alu_a;
  } vec_t;

  task automatic test_ops();
    vec_t v[10];
    logic [7:0] res, oa;
    logic [3:0] fl;
    logic       err;
    logic [1:0] ctrl;
    int         lat;
    //        name        op      a      b      res    flags    err  lat ctrl  alu_a
    v[0] = '{"add_ovf",  3'b000, 8'h7F, 8'h01, 8'h80, 4'b1001, 1'b0, 2, 2'b00, 8'h7F};
    v[1] = '{"add_wrap", 3'b000, 8'hFF, 8'h01, 8'h00, 4'b0110, 1'b0, 2, 2'b00, 8'hFF};
    v[2] = '{"sub_zero", 3'b001, 8'h05, 8'h05, 8'h00, 4'b0110, 1'b0, 2, 2'b01, 8'h05};
    v[3] = '{"cmp_lt",   3'b100, 8'h03, 8'h04, 8'h00, 4'b1000, 1'b0, 2, 2'b01, 8'h03};
    v[4] = '{"neg_min",  3'b101, 8'h55, 8'h80, 8'h80, 4'b1001, 1'b0, 2, 2'b01, 8'h00};
    v[5] = '{"mov",      3'b110, 8'h0F, 8'hA5, 8'hA5, 4'b1000, 1'b0, 2, 2'b11, 8'h00};
    v[6] = '{"and_zero", 3'b010, 8'hF0, 8'h0F, 8'h00, 4'b0100, 1'b0, 2, 2'b10, 8'hF0};
    v[7] = '{"or_ones",  3'b011, 8'hF0, 8'h0F, 8'hFF, 4'b1000, 1'b0, 2, 2'b11, 8'hF0};
    // illegal: ALU registers keep the OR operands/control
    v[8] = '{"illegal",  3'b111, 8'h12, 8'h34, 8'h00, 4'b0000, 1'b1, 1, 2'b11, 8'hF0};
    v[9] = '{"add_after_err", 3'b000, 8'h02, 8'h03, 8'h05, 4'b0000, 1'b0, 2, 2'b00, 8'h02};
    for (int i = 0; i < 10; i++) begin
      issue(v[i].op, v[i].a, v[i].b, res, fl, err, lat, ctrl, oa);
      checks++;
      if (res !== v[i].res || fl !== v[i].fl || err !== v[i].err) begin
        fails++;
        $display("FAIL %s response: res=%h fl=%b err=%b (required res=%h fl=%b err=%b)",
                 v[i].name, res, fl, err, v[i].res, v[i].fl, v[i].err);
      end
      checks++;
      if (lat !== v[i].lat) begin
        fails++;
        $display("FAIL %s latency: %0d cycles (required %0d)", v[i].name, lat, v[i].lat);
      end
      checks++;
      if (ctrl !== v[i].ctrl || oa !== v[i].alu_a) begin
        fails++;
        $display("FAIL %s alu_drive: ctrl=%b a=%h (required ctrl=%b a=%h)",
                 v[i].name, ctrl, oa, v[i].ctrl, v[i].alu_a);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] hold_res;
    logic [3:0] hold_fl;
    int         n;
    // SUB 0x10-0x20 = 0xF0, borrow (C=0), N=1
    @(negedge clk);
    req_valid = 1'b1; req_op = 3'b001; req_a = 8'h10; req_b = 8'h20;
    @(posedge clk);
    @(negedge clk);
    // keep a second request pending for the whole stall
    req_op = 3'b000; req_a = 8'h33; req_b = 8'h44;
    n = 0;
    while (!rsp_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    hold_res = rsp_result; hold_fl = rsp_flags;
    checks++;
    if (rsp_valid !== 1'b1 || hold_res !== 8'hF0 || hold_fl !== 4'b1000) begin
      fails++;
      $display("FAIL bp_first: vld=%b res=%h fl=%b (required 1 f0 1000)", rsp_valid, hold_res, hold_fl);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b1 || rsp_result !== 8'hF0 || rsp_flags !== 4'b1000 ||
          rsp_error !== 1'b0 || req_ready !== 1'b0 || alu_a !== 8'h10) begin
        fails++;
        $display("FAIL bp_stall%0d: vld=%b res=%h fl=%b err=%b rdy=%b alu_a=%h (required 1 f0 1000 0 0 10)",
                 i, rsp_valid, rsp_result, rsp_flags, rsp_error, req_ready, alu_a);
      end
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    // handshake edge returns to IDLE only; pending request not yet taken
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || alu_a !== 8'h10 || rsp_result !== 8'hF0) begin
      fails++;
      $display("FAIL bp_turnaround: vld=%b rdy=%b alu_a=%h res=%h (required 0 1 10 f0)",
               rsp_valid, req_ready, alu_a, rsp_result);
    end
    @(negedge clk);
    req_valid = 1'b0;
    checks++;
    if (req_ready !== 1'b0 || alu_a !== 8'h33 || alu_b !== 8'h44) begin
      fails++;
      $display("FAIL bp_second_accept: rdy=%b a=%h b=%h (required 0 33 44)", req_ready, alu_a, alu_b);
    end
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_result !== 8'h77 || rsp_flags !== 4'b0000) begin
      fails++;
      $display("FAIL bp_second_rsp: vld=%b res=%h fl=%b (required 1 77 0000)", rsp_valid, rsp_result, rsp_flags);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset_in_exec();
    logic [7:0] res, oa;
    logic [3:0] fl;
    logic       err;
    logic [1:0] ctrl;
    int         lat;
    @(negedge clk);
    req_valid = 1'b1; req_op = 3'b001; req_a = 8'h11; req_b = 8'h22;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    rst = 1'b1;
    #1;
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_result !== 8'h00 ||
        rsp_flags !== 4'h0 || rsp_error !== 1'b0 || alu_a !== 8'h00 ||
        alu_b !== 8'h00 || alu_ctrl !== 2'b00) begin
      fails++;
      $display("FAIL rst_exec_async: rdy=%b vld=%b res=%h fl=%b err=%b a=%h b=%h ctrl=%b (required 1 0 00 0000 0 00 00 00)",
               req_ready, rsp_valid, rsp_result, rsp_flags, rsp_error, alu_a, alu_b, alu_ctrl);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
        fails++;
        $display("FAIL rst_exec_no_rsp%0d: vld=%b rdy=%b (required 0 1)", i, rsp_valid, req_ready);
      end
    end
    issue(3'b000, 8'h02, 8'h03, res, fl, err, lat, ctrl, oa);
    checks++;
    if (res !== 8'h05 || fl !== 4'b0000 || err !== 1'b0 || lat !== 2) begin
      fails++;
      $display("FAIL rst_exec_next_add: res=%h fl=%b err=%b lat=%0d (required 05 0000 0 2)", res, fl, err, lat);
    end
  endtask

  initial begin
    test_reset();
    test_ops();
    test_backpressure();
    test_reset_in_exec();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
